sat_narrow_unit: RTL and testbench



---
 rtl/sat_narrow_unit.sv | 104 ++++++++++
 tb/tb_sat_narrow_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sat_narrow_unit.sv
// Narrows 32-bit register words to 16-bit halfwords (truncate / signed / unsigned
// saturate) behind a single registered valid/ready stage, with overflow statistics.
module sat_narrow_unit #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_ovf,
  input  logic             clr_stat,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count
);

  logic             valid_q, valid_d;
  logic [15:0]      data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        accept;
  logic        signed_loss;
  logic        unsigned_loss;
  logic [15:0] narrow;
  logic        narrow_ovf;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Bits 31..15 must all match the halfword sign bit to fit a signed 16-bit value.
  assign signed_loss   = !((&in_data[31:15]) || !(|in_data[31:15]));
  assign unsigned_loss = |in_data[31:16];

  always_comb begin
    narrow     = in_data[15:0];
    narrow_ovf = signed_loss;
    case (in_mode)
      2'd1: begin
        narrow_ovf = signed_loss;
        if (signed_loss) narrow = in_data[31] ? 16'h8000 : 16'h7FFF;
      end
      2'd2: begin
        narrow_ovf = unsigned_loss;
        if (unsigned_loss) narrow = 16'hFFFF;
      end
      default: begin
        narrow     = in_data[15:0];
        narrow_ovf = signed_loss;
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = narrow;
      ovf_d   = narrow_ovf;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Clear is applied before the current event so a simultaneous overflow counts as one.
  always_comb begin
    sticky_d = clr_stat ? 1'b0 : sticky_q;
    cnt_d    = clr_stat ? '0 : cnt_q;
    if (accept && narrow_ovf) begin
      sticky_d = 1'b1;
      if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_ovf    = ovf_q;
  assign sticky_ovf = sticky_q;
  assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_sat_narrow_unit.sv
// Directed bench for sat_narrow_unit: scoreboard queue of expected halfwords
// plus a reference model of the narrowing arithmetic and overflow statistics.
module tb_sat_narrow_unit;

  localparam int unsigned CW = 2;

  logic          Clk;
  logic          Rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic          out_ovf;
  logic          clr_stat;
  logic          sticky_ovf;
  logic [CW-1:0] ovf_count;

  sat_narrow_unit #(.CNT_W(CW)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .clr_stat   (clr_stat),
    .sticky_ovf (sticky_ovf),
    .ovf_count  (ovf_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned n_cmp;
  int unsigned n_bad;

  logic [16:0]   sb_q[$];
  logic [15:0]   exp_data;
  logic          exp_ovf;
  logic          exp_sticky;
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference narrowing, written in terms of numeric ranges rather than bit patterns.
  function automatic logic [16:0] ref_narrow(input logic [31:0] d, input logic [1:0] m);
    longint s;
    logic   sov;
    s   = longint'($signed(d));
    sov = (s > 32767) || (s < -32768);
    case (m)
      2'd1: begin
        if (s > 32767)       return {1'b1, 16'h7FFF};
        else if (s < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, d[15:0]};
      end
      2'd2: begin
        if (d > 32'h0000FFFF) return {1'b1, 16'hFFFF};
        else                  return {1'b0, d[15:0]};
      end
      default: return {sov, d[15:0]};
    endcase
  endfunction

  task automatic step(input logic rst, input logic iv, input logic [31:0] d,
                      input logic [1:0] m, input logic ordy, input logic clr);
    logic        fire;
    logic        consume;
    logic [16:0] r;
    logic [16:0] head;
    Rst       = rst;
    in_valid  = iv;
    in_data   = d;
    in_mode   = m;
    out_ready = ordy;
    clr_stat  = clr;
    #1;
    if (!rst) chk("in_ready", 32'(in_ready), 32'(sb_q.size() == 0 || ordy));
    fire    = !rst && iv && (sb_q.size() == 0 || ordy);
    consume = !rst && (sb_q.size() != 0) && ordy;
    if (consume) begin
      head = sb_q.pop_front();
      chk("consume_data", 32'(out_data), 32'(head[15:0]));
      chk("consume_ovf", 32'(out_ovf), 32'(head[16]));
    end
    r = ref_narrow(d, m);
    if (rst) begin
      sb_q.delete();
      exp_data   = 16'h0000;
      exp_ovf    = 1'b0;
      exp_sticky = 1'b0;
      exp_cnt    = '0;
    end else begin
      if (clr) begin
        exp_sticky = 1'b0;
        exp_cnt    = '0;
      end
      if (fire) begin
        sb_q.push_back(r);
        exp_data = r[15:0];
        exp_ovf  = r[16];
        if (r[16]) begin
          exp_sticky = 1'b1;
          if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
      end
    end
    @(posedge Clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    chk("out_data", 32'(out_data), 32'(exp_data));
    chk("out_ovf", 32'(out_ovf), 32'(exp_ovf));
    chk("sticky_ovf", 32'(sticky_ovf), 32'(exp_sticky));
    chk("ovf_count", 32'(ovf_count), 32'(exp_cnt));
  endtask

  initial begin
    logic [15:0] h;
    n_cmp = 0;
    n_bad = 0;
    exp_data = '0; exp_ovf = 1'b0; exp_sticky = 1'b0; exp_cnt = '0;
    Rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0; clr_stat = 1'b0;

    step(1, 0, 32'h0, 2'd0, 0, 0);
    step(1, 0, 32'h0, 2'd0, 0, 0);

    // Reset while an overflowing sample is held under backpressure.
    step(0, 1, 32'h00012345, 2'd1, 0, 0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    step(1, 1, 32'h00000055, 2'd0, 0, 0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h0000);
    chk("rst_sticky", 32'(sticky_ovf), 32'd0);
    chk("rst_cnt", 32'(ovf_count), 32'd0);

    // Mode 1 back-to-back.
    step(0, 1, 32'h00001234, 2'd1, 1, 0);
    chk("m1_a", 32'({out_ovf, out_data}), 32'h01234);
    step(0, 1, 32'hFFFF8000, 2'd1, 1, 0);
    chk("m1_b", 32'({out_ovf, out_data}), 32'h08000);
    step(0, 1, 32'h00012345, 2'd1, 1, 0);
    chk("m1_c", 32'({out_ovf, out_data}), 32'h17FFF);
    step(0, 1, 32'h80000000, 2'd1, 1, 0);
    chk("m1_d", 32'({out_ovf, out_data}), 32'h18000);

    // Mode 2.
    step(0, 1, 32'h0000FFFF, 2'd2, 1, 0);
    chk("m2_a", 32'({out_ovf, out_data}), 32'h0FFFF);
    step(0, 1, 32'h00010000, 2'd2, 1, 0);
    chk("m2_b", 32'({out_ovf, out_data}), 32'h1FFFF);

    // Mode 0 and reserved mode 3.
    step(0, 1, 32'h12345678, 2'd0, 1, 0);
    chk("m0", 32'({out_ovf, out_data}), 32'h15678);
    step(0, 1, 32'h12345678, 2'd3, 1, 0);
    chk("m3", 32'({out_ovf, out_data}), 32'h15678);
    step(0, 1, 32'hFFFF0001, 2'd2, 1, 0);
    step(0, 1, 32'hFFFFFFFF, 2'd0, 1, 0);

    // Drain: valid drops, data holds.
    step(0, 0, 32'hDEADBEEF, 2'd1, 1, 0);
    chk("drain_hold", 32'(out_data), 32'hFFFF);

    // Sign-extended halfwords survive mode 1 unchanged.
    for (int i = 0; i < 8; i++) begin
      h = 16'($urandom);
      if (i == 0) h = 16'h7FFF;
      if (i == 1) h = 16'h8000;
      step(0, 1, {{16{h[15]}}, h}, 2'd1, 1, 0);
      chk("roundtrip", 32'({out_ovf, out_data}), 32'({1'b0, h}));
    end

    // Backpressure.
    step(0, 1, 32'h00000042, 2'd0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h00000043, 2'd0, 0, 0);
      chk("bp_hold", 32'(out_data), 32'h0042);
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    step(0, 1, 32'h00000043, 2'd0, 1, 0);
    chk("bp_next", 32'(out_data), 32'h0043);
    step(0, 0, 32'h0, 2'd0, 1, 0);

    // Statistics with a 2-bit counter.
    step(0, 0, 32'h0, 2'd0, 1, 1);
    chk("clr_cnt0", 32'(ovf_count), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h00012345, 2'd1, 1, 0);
    chk("cnt_sat", 32'(ovf_count), 32'd3);
    chk("sticky_set", 32'(sticky_ovf), 32'd1);
    step(0, 1, 32'h00010000, 2'd2, 1, 1);
    chk("clr_with_evt_cnt", 32'(ovf_count), 32'd1);
    chk("clr_with_evt_sticky", 32'(sticky_ovf), 32'd1);
    step(0, 0, 32'h0, 2'd0, 1, 1);
    chk("clr_alone_cnt", 32'(ovf_count), 32'd0);
    chk("clr_alone_sticky", 32'(sticky_ovf), 32'd0);
    chk("clr_keeps_data", 32'(out_data), 32'hFFFF);

    // Non-overflowing accepts leave statistics alone.
    step(0, 1, 32'h00000007, 2'd2, 1, 0);
    step(0, 0, 32'h0, 2'd0, 1, 0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
